// File: rtl/sdm_pkg.sv
// rtl/sdm_pkg.sv - shared order encodings, LFSR seed and order normalisation for sdm_mash
package sdm_pkg;

    localparam logic [1:0]  SDM_ORD1      = 2'd1;
    localparam logic [1:0]  SDM_ORD2      = 2'd2;
    localparam logic [1:0]  SDM_ORD3      = 2'd3;
    localparam logic [14:0] SDM_LFSR_SEED = 15'h0001;
    localparam int          SDM_OW_MIN    = 4;

    // Order 0 has no meaning of its own and behaves as a first-order modulator
    function automatic logic [1:0] sdm_norm_order(input logic [1:0] ord);
        return (ord == 2'd0) ? SDM_ORD1 : ord;
    endfunction

endpackage

// File: rtl/sdm_acc.sv
// rtl/sdm_acc.sv - registered W-bit wrap-around accumulator stage with carry-out and zero gating
module sdm_acc #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic         i_zero,
    input  logic         i_ci,
    input  logic [W-1:0] i_a,
    output logic [W-1:0] o_residue,
    output logic         o_carry
);

    logic [W-1:0] r_acc;
    logic [W:0]   w_sum;

    // The overflow bit is the modulator carry; a gated stage reports no carry
    assign w_sum     = {1'b0, r_acc} + {1'b0, i_a} + {{W{1'b0}}, i_ci};
    assign o_residue = w_sum[W-1:0];
    assign o_carry   = w_sum[W] & ~i_zero;

    // Accumulator keeps the residue; a gated stage is held at zero while stepping
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= i_zero ? '0 : w_sum[W-1:0];
        end
    end

endmodule

// File: rtl/sdm_mash.sv
// rtl/sdm_mash.sv - MASH 1-1-1 sigma-delta modulator, run-time order 1..3, optional LFSR dither (SDM_MASH_DITHER_EN)
module sdm_mash
    import sdm_pkg::*;
#(
    parameter int W  = 16,
    parameter int OW = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic                 clr,
    input  logic [1:0]           order,
    input  logic [W-1:0]         frac,
    output logic signed [OW-1:0] dout,
    output logic                 dout_vld,
    output logic                 ovf
);

    logic [1:0]         w_ord;
    logic               w_zero2;
    logic               w_zero3;
    logic               w_dith;
    logic [W-1:0]       w_res1;
    logic [W-1:0]       w_res2;
    logic               w_c1;
    logic               w_c2;
    logic               w_c3;
    logic [3:0]         w_t1;
    logic [3:0]         w_t2;
    logic [3:0]         w_t3;
    logic signed [3:0]  w_y;

    logic               r_c2_d;
    logic               r_c3_d;
    logic               r_c3_dd;
    logic [1:0]         r_ord_last;
    logic               r_ord_vld;

    assign w_ord   = sdm_norm_order(order);
    assign w_zero2 = (w_ord == SDM_ORD1);
    assign w_zero3 = (w_ord != SDM_ORD3);

`ifdef SDM_MASH_DITHER_EN
    logic [14:0] r_lfsr;

    // x^15 + x^14 + 1 Fibonacci LFSR, stepped with the modulator
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_lfsr <= SDM_LFSR_SEED;
        end else if (clr) begin
            r_lfsr <= SDM_LFSR_SEED;
        end else if (en) begin
            r_lfsr <= {r_lfsr[13:0], r_lfsr[14] ^ r_lfsr[13]};
        end
    end

    assign w_dith = r_lfsr[0];
`else
    assign w_dith = 1'b0;
`endif

    sdm_acc #(.W(W)) u_acc1 (
        .clk       (clk),
        .rstn      (rstn),
        .i_en      (en),
        .i_clr     (clr),
        .i_zero    (1'b0),
        .i_ci      (w_dith),
        .i_a       (frac),
        .o_residue (w_res1),
        .o_carry   (w_c1)
    );

    sdm_acc #(.W(W)) u_acc2 (
        .clk       (clk),
        .rstn      (rstn),
        .i_en      (en),
        .i_clr     (clr),
        .i_zero    (w_zero2),
        .i_ci      (1'b0),
        .i_a       (w_res1),
        .o_residue (w_res2),
        .o_carry   (w_c2)
    );

    sdm_acc #(.W(W)) u_acc3 (
        .clk       (clk),
        .rstn      (rstn),
        .i_en      (en),
        .i_clr     (clr),
        .i_zero    (w_zero3),
        .i_ci      (1'b0),
        .i_a       (w_res2),
        .o_residue (),
        .o_carry   (w_c3)
    );

    // Noise-cancellation terms; a disabled stage contributes nothing, keeping the range tight on order switches
    assign w_t1 = {3'b000, w_c1};
    assign w_t2 = w_zero2 ? 4'd0 : ({3'b000, w_c2} - {3'b000, r_c2_d});
    assign w_t3 = w_zero3 ? 4'd0 : ({3'b000, w_c3} - {2'b00, r_c3_d, 1'b0} + {3'b000, r_c3_dd});
    assign w_y  = w_t1 + w_t2 + w_t3;

    // Remember the last order seen so a change during stepping can be flagged
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ord_last <= SDM_ORD1;
            r_ord_vld  <= 1'b0;
        end else begin
            r_ord_last <= w_ord;
            r_ord_vld  <= 1'b1;
        end
    end

    // Carry delay line, registered output, valid strobe and sticky order-change flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_c2_d   <= 1'b0;
            r_c3_d   <= 1'b0;
            r_c3_dd  <= 1'b0;
            dout     <= '0;
            dout_vld <= 1'b0;
            ovf      <= 1'b0;
        end else if (clr) begin
            r_c2_d   <= 1'b0;
            r_c3_d   <= 1'b0;
            r_c3_dd  <= 1'b0;
            dout     <= '0;
            dout_vld <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            dout_vld <= en;
            if (en) begin
                r_c2_d  <= w_c2;
                r_c3_d  <= w_c3;
                r_c3_dd <= w_zero3 ? 1'b0 : r_c3_d;
                dout    <= OW'(w_y);
                if (r_ord_vld && (w_ord != r_ord_last)) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

endmodule
